// File: rtl/spi_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// spi_ctrl_pkg
// Shared types and constants for the SPI command controller:
//   opcode_t      - header opcode field encoding
//   state_t       - main controller states
//   load_phase_t  - sub-steps used while loading a word into the SPI transmitter
//   HDR_*_LSB     - bit positions of the header fields
//   STATUS_MAGIC  - upper byte of the status word
// -----------------------------------------------------------------------------
package spi_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_WRITE  = 2'b01,
    OP_READ   = 2'b10,
    OP_STATUS = 2'b11
  } opcode_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    RD_FETCH,
    RD_LOAD,
    RD_WAIT,
    ST_LOAD
  } state_t;

  // Transmit-load sequence shared by RD_LOAD and ST_LOAD.
  typedef enum logic [2:0] {
    LD_WAIT_DATA, // reg_re is high this cycle, read data arrives next cycle
    LD_CAPTURE,   // reg_rdata valid, capture it
    LD_READY,     // wait for the SPI transmitter to be idle
    LD_HOLD,      // first tx_valid cycle
    LD_DONE       // second tx_valid cycle
  } load_phase_t;

  // Header layout: [15:14] opcode, [13:8] start address, [7:0] count.
  localparam int HDR_OP_LSB   = 14;
  localparam int HDR_ADDR_LSB = 8;
  localparam int HDR_CNT_LSB  = 0;

  localparam logic [7:0] STATUS_MAGIC = 8'hA5;

endpackage

// File: rtl/spi_cmd_ctrl_if.sv
// -----------------------------------------------------------------------------
// spi_cmd_ctrl_if
// Bundles the SPI-slave side and register-bus side of the command controller.
//   cs, rx_valid, rx_data, tx_ready  : from the SPI slave
//   tx_valid, tx_data                : to the SPI slave transmit register
//   reg_we, reg_addr, reg_wdata,
//   reg_re, reg_rdata                : register bus (read data one cycle after reg_re)
//   busy                             : controller not idle
// modport master : the controller; modport slave : its environment.
// -----------------------------------------------------------------------------
interface spi_cmd_ctrl_if #(
  parameter int DATA_SIZE  = 16,
  parameter int ADDR_WIDTH = 6
) ();

  logic                  cs;
  logic                  rx_valid;
  logic [DATA_SIZE-1:0]  rx_data;
  logic                  tx_valid;
  logic [DATA_SIZE-1:0]  tx_data;
  logic                  tx_ready;
  logic                  reg_we;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [DATA_SIZE-1:0]  reg_wdata;
  logic                  reg_re;
  logic [DATA_SIZE-1:0]  reg_rdata;
  logic                  busy;

  modport master (
    input  cs, rx_valid, rx_data, tx_ready, reg_rdata,
    output tx_valid, tx_data, reg_we, reg_addr, reg_wdata, reg_re, busy
  );

  modport slave (
    output cs, rx_valid, rx_data, tx_ready, reg_rdata,
    input  tx_valid, tx_data, reg_we, reg_addr, reg_wdata, reg_re, busy
  );

endinterface

// File: rtl/spi_cmd_ctrl_word_sync.sv
// -----------------------------------------------------------------------------
// spi_word_sync
// Brings the asynchronous chip select into the clk domain (2-FF synchronizer)
// and turns the rx_valid level into a one-cycle word event on its rising edge.
//   clk, rst_n : clock, async active-low reset
//   cs         : raw chip select (active-low, asynchronous)
//   rx_valid   : received-word level from the SPI slave
//   cs_sync    : synchronized chip select
//   word_evt   : one-cycle pulse per new received word
// -----------------------------------------------------------------------------
module spi_word_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic cs,
  input  logic rx_valid,
  output logic cs_sync,
  output logic word_evt
);

  logic cs_meta_reg;
  logic cs_sync_reg;
  logic rx_valid_q;

  // Synchronizer resets to "deselected" and the edge detector to "high", so a
  // rx_valid that is already high when reset releases produces no event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_meta_reg <= 1'b1;
      cs_sync_reg <= 1'b1;
      rx_valid_q  <= 1'b1;
    end else begin
      cs_meta_reg <= cs;
      cs_sync_reg <= cs_meta_reg;
      rx_valid_q  <= rx_valid;
    end
  end

  assign cs_sync  = cs_sync_reg;
  assign word_evt = rx_valid & ~rx_valid_q;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// spi_cmd_ctrl
// Decodes header words received over SPI and runs register write bursts,
// register read bursts and a status readback.
//   clk, rst_n : clock, async active-low reset
//   bus        : spi_cmd_ctrl_if.master (SPI slave side + register bus + busy)
// Parameters: DATA_SIZE (SPI word width), ADDR_WIDTH (register address width),
//             CNT_WIDTH (burst count field width; burst length = count + 1).
// -----------------------------------------------------------------------------
module spi_cmd_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int DATA_SIZE  = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int CNT_WIDTH  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_cmd_ctrl_if.master     bus
);

  logic cs_sync;
  logic word_evt;

  spi_word_sync u_word_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs       (bus.cs),
    .rx_valid (bus.rx_valid),
    .cs_sync  (cs_sync),
    .word_evt (word_evt)
  );

  state_t                state_reg;
  load_phase_t           phase_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [CNT_WIDTH-1:0]  count_reg;
  logic [CNT_WIDTH-1:0]  burst_cnt_reg;
  logic [7:0]            frame_cnt_reg;
  logic [DATA_SIZE-1:0]  rd_word_reg;
  logic                  tx_valid_reg;
  logic [DATA_SIZE-1:0]  tx_data_reg;
  logic                  reg_we_reg;
  logic [ADDR_WIDTH-1:0] reg_addr_reg;
  logic [DATA_SIZE-1:0]  reg_wdata_reg;
  logic                  reg_re_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      phase_reg     <= LD_WAIT_DATA;
      addr_reg      <= '0;
      count_reg     <= '0;
      burst_cnt_reg <= '0;
      frame_cnt_reg <= '0;
      rd_word_reg   <= '0;
      tx_valid_reg  <= 1'b0;
      tx_data_reg   <= '0;
      reg_we_reg    <= 1'b0;
      reg_addr_reg  <= '0;
      reg_wdata_reg <= '0;
      reg_re_reg    <= 1'b0;
    end else begin
      reg_we_reg <= 1'b0;
      reg_re_reg <= 1'b0;
      if (cs_sync) begin
        // Master deselected: drop whatever is in flight; frame_cnt is kept.
        state_reg     <= IDLE;
        phase_reg     <= LD_WAIT_DATA;
        addr_reg      <= '0;
        count_reg     <= '0;
        burst_cnt_reg <= '0;
        tx_valid_reg  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (word_evt) begin
              addr_reg      <= bus.rx_data[HDR_ADDR_LSB +: ADDR_WIDTH];
              count_reg     <= bus.rx_data[HDR_CNT_LSB +: CNT_WIDTH];
              burst_cnt_reg <= '0;
              case (opcode_t'(bus.rx_data[HDR_OP_LSB +: 2]))
                OP_WRITE: state_reg <= WR_DATA;
                OP_READ:  state_reg <= RD_FETCH;
                OP_STATUS: begin
                  // Status word is snapshotted now, so it reports completed
                  // commands before this one.
                  rd_word_reg <= DATA_SIZE'({STATUS_MAGIC, frame_cnt_reg});
                  phase_reg   <= LD_READY;
                  state_reg   <= ST_LOAD;
                end
                default: state_reg <= IDLE;
              endcase
            end
          end
          WR_DATA: begin
            if (word_evt) begin
              reg_we_reg    <= 1'b1;
              reg_addr_reg  <= addr_reg;
              reg_wdata_reg <= bus.rx_data;
              addr_reg      <= addr_reg + 1'b1;
              if (burst_cnt_reg == count_reg) begin
                state_reg     <= IDLE;
                frame_cnt_reg <= frame_cnt_reg + 1'b1;
              end else begin
                burst_cnt_reg <= burst_cnt_reg + 1'b1;
              end
            end
          end
          RD_FETCH: begin
            reg_re_reg   <= 1'b1;
            reg_addr_reg <= addr_reg;
            phase_reg    <= LD_WAIT_DATA;
            state_reg    <= RD_LOAD;
          end
          RD_LOAD, ST_LOAD: begin
            // Word events are deliberately ignored here.
            case (phase_reg)
              LD_WAIT_DATA: phase_reg <= LD_CAPTURE;
              LD_CAPTURE: begin
                rd_word_reg <= bus.reg_rdata;
                phase_reg   <= LD_READY;
              end
              LD_READY: begin
                if (bus.tx_ready) begin
                  tx_valid_reg <= 1'b1;
                  tx_data_reg  <= rd_word_reg;
                  phase_reg    <= LD_HOLD;
                end
              end
              LD_HOLD: phase_reg <= LD_DONE;
              LD_DONE: begin
                tx_valid_reg <= 1'b0;
                phase_reg    <= LD_WAIT_DATA;
                if (state_reg == ST_LOAD) begin
                  state_reg     <= IDLE;
                  frame_cnt_reg <= frame_cnt_reg + 1'b1;
                end else begin
                  state_reg <= RD_WAIT;
                end
              end
              default: phase_reg <= LD_WAIT_DATA;
            endcase
          end
          RD_WAIT: begin
            if (word_evt) begin
              addr_reg <= addr_reg + 1'b1;
              if (burst_cnt_reg == count_reg) begin
                state_reg     <= IDLE;
                frame_cnt_reg <= frame_cnt_reg + 1'b1;
              end else begin
                burst_cnt_reg <= burst_cnt_reg + 1'b1;
                state_reg     <= RD_FETCH;
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign bus.tx_valid  = tx_valid_reg;
  assign bus.tx_data   = tx_data_reg;
  assign bus.reg_we    = reg_we_reg;
  assign bus.reg_addr  = reg_addr_reg;
  assign bus.reg_wdata = reg_wdata_reg;
  assign bus.reg_re    = reg_re_reg;
  assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_cmd_ctrl
// Self-checking bench for spi_cmd_ctrl: directed scenarios plus randomized
// command streams, checked against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_spi_cmd_ctrl;

  localparam int DW = 16;
  localparam int AW = 6;
  localparam int CW = 8;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_cmd_ctrl_if #(.DATA_SIZE(DW), .ADDR_WIDTH(AW)) bus ();

  spi_cmd_ctrl #(.DATA_SIZE(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- register-bus slave (environment) ----------------
  logic [DW-1:0] slave_mem [0:63];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) slave_mem[i] <= 16'(i * 3);
    end else begin
      if (bus.reg_we) slave_mem[bus.reg_addr] <= bus.reg_wdata;
      if (bus.reg_re) bus.reg_rdata <= slave_mem[bus.reg_addr];
    end
  end

  // ---------------- tx_ready driver ----------------
  bit rdy_mode = 1'b0;
  bit rdy_force = 1'b0;
  initial begin
    bus.tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.tx_ready = rdy_mode ? rdy_force : ($urandom_range(0, 2) != 0);
    end
  end

  // ---------------- monitors ----------------
  wr_t           got_wr[$];
  logic [DW-1:0] got_tx[$];
  int            got_len[$];
  int            tx_len = 0;
  logic [DW-1:0] tx_last;
  logic          prev_ready = 1'b0;
  int            tx_bad = 0;
  int            we_cnt = 0;
  int            re_cnt = 0;
  wr_t           mon_w;

  always @(negedge clk) begin
    if (bus.reg_we) begin
      mon_w.a = bus.reg_addr;
      mon_w.d = bus.reg_wdata;
      got_wr.push_back(mon_w);
      we_cnt++;
    end
    if (bus.reg_re) re_cnt++;
    if (bus.tx_valid) begin
      if (tx_len == 0 && !prev_ready) tx_bad++;
      tx_len++;
      tx_last = bus.tx_data;
    end else if (tx_len != 0) begin
      got_tx.push_back(tx_last);
      got_len.push_back(tx_len);
      tx_len = 0;
    end
    prev_ready = bus.tx_ready;
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [0:63];
  int            ref_frame;
  wr_t           exp_wr[$];
  logic [DW-1:0] exp_tx[$];

  task automatic ref_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = 16'(i * 3);
    ref_frame = 0;
  endtask

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- SPI master model ----------------
  task automatic send_word(input logic [DW-1:0] w);
    bus.rx_data  = w;
    bus.rx_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_tx(input int n);
    int t;
    t = 0;
    while (got_tx.size() < n && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) check_val("tx_timeout", got_tx.size(), n);
  endtask

  task automatic cmd_write(input int a, input int n, input logic [DW-1:0] seed);
    logic [DW-1:0] d;
    wr_t e;
    send_word({2'b01, 6'(a), 8'(n - 1)});
    for (int k = 0; k < n; k++) begin
      d = (seed != 0) ? 16'(seed * (k + 1)) : 16'($urandom);
      send_word(d);
      e.a = 6'((a + k) % 64);
      e.d = d;
      exp_wr.push_back(e);
      ref_mem[(a + k) % 64] = d;
    end
    ref_frame++;
  endtask

  task automatic cmd_read(input int a, input int n);
    send_word({2'b10, 6'(a), 8'(n - 1)});
    for (int k = 0; k < n; k++) begin
      wait_tx(k + 1);
      exp_tx.push_back(ref_mem[(a + k) % 64]);
      send_word(16'($urandom));
    end
    ref_frame++;
  endtask

  task automatic cmd_status();
    send_word({2'b11, 14'($urandom)});
    wait_tx(1);
    exp_tx.push_back({8'hA5, 8'(ref_frame % 256)});
    ref_frame++;
  endtask

  task automatic cmd_nop();
    send_word({2'b00, 14'($urandom)});
  endtask

  task automatic compare_all(input string tag);
    wr_t g;
    wr_t e;
    repeat (4) @(posedge clk);
    #1;
    check_val({tag, " wr_count"}, got_wr.size(), exp_wr.size());
    while (got_wr.size() > 0 && exp_wr.size() > 0) begin
      g = got_wr.pop_front();
      e = exp_wr.pop_front();
      check_val({tag, " wr_addr"}, 32'(g.a), 32'(e.a));
      check_val({tag, " wr_data"}, 32'(g.d), 32'(e.d));
    end
    got_wr.delete();
    exp_wr.delete();
    check_val({tag, " tx_count"}, got_tx.size(), exp_tx.size());
    while (got_tx.size() > 0 && exp_tx.size() > 0) begin
      check_val({tag, " tx_data"}, 32'(got_tx.pop_front()), 32'(exp_tx.pop_front()));
      check_val({tag, " tx_len"}, got_len.pop_front(), 2);
    end
    got_tx.delete();
    got_len.delete();
    exp_tx.delete();
    check_val({tag, " busy"}, 32'(bus.busy), 0);
    check_val({tag, " tx_ready_rule"}, tx_bad, 0);
    $display("[%0t] %s complete, frames=%0d", $time, tag, ref_frame);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, " busy"}, 32'(bus.busy), 0);
    check_val({tag, " tx_valid"}, 32'(bus.tx_valid), 0);
    check_val({tag, " tx_data"}, 32'(bus.tx_data), 0);
    check_val({tag, " reg_we"}, 32'(bus.reg_we), 0);
    check_val({tag, " reg_re"}, 32'(bus.reg_re), 0);
    check_val({tag, " reg_addr"}, 32'(bus.reg_addr), 0);
    check_val({tag, " reg_wdata"}, 32'(bus.reg_wdata), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    int we_before;
    int re_before;
    int op;
    bus.cs       = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    ref_reset();

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero("reset");

    bus.cs = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Write burst of two at address 10
    cmd_write(10, 2, 16'h1111);
    compare_all("write_10");

    // Write burst across the top of the address space
    cmd_write(63, 2, 16'h0ABC);
    compare_all("write_wrap");

    // Read burst of three from address 5 (slave holds addr*3)
    cmd_read(5, 3);
    compare_all("read_5");

    // Status after three completed commands
    cmd_status();
    compare_all("status_3");

    // Deselect after one of four write words
    send_word({2'b01, 6'd20, 8'd3});
    send_word(16'hBEEF);
    begin
      wr_t e;
      e.a = 6'd20;
      e.d = 16'hBEEF;
      exp_wr.push_back(e);
      ref_mem[20] = 16'hBEEF;
    end
    bus.cs = 1'b1;
    cyc = 0;
    while (bus.busy && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_val("abort_latency_le3", 32'(cyc <= 3), 1);
    send_word(16'h1234);
    send_word(16'h5678);
    bus.cs = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    compare_all("abort");
    cmd_status();
    compare_all("status_after_abort");

    // Words arriving while a read word is still being loaded are ignored
    rdy_mode  = 1'b1;
    rdy_force = 1'b0;
    send_word({2'b10, 6'd40, 8'd0});
    send_word(16'h5555);
    rdy_force = 1'b1;
    wait_tx(1);
    exp_tx.push_back(ref_mem[40]);
    send_word(16'h0000);
    ref_frame++;
    rdy_mode = 1'b0;
    compare_all("early_word");

    // Randomized command stream
    for (int i = 0; i < 30; i++) begin
      op = $urandom_range(0, 3);
      case (op)
        0: cmd_nop();
        1: cmd_write($urandom_range(0, 63), $urandom_range(1, 6), '0);
        2: cmd_read($urandom_range(0, 63), $urandom_range(1, 6));
        default: cmd_status();
      endcase
      compare_all($sformatf("rand%0d_op%0d", i, op));
    end

    // Drive the frame counter past 255 to see it wrap
    while (ref_frame < 258) begin
      cmd_status();
      compare_all($sformatf("frame_status%0d", ref_frame));
    end

    // Reset in the middle of a write burst, rx_valid held high across release
    send_word({2'b01, 6'd30, 8'd3});
    send_word(16'hCAFE);
    begin
      wr_t e;
      e.a = 6'd30;
      e.d = 16'hCAFE;
      exp_wr.push_back(e);
    end
    repeat (2) @(posedge clk);
    #1;
    we_before = we_cnt;
    re_before = re_cnt;
    bus.rx_data  = 16'hDEAD;
    bus.rx_valid = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ref_reset();
    repeat (5) @(posedge clk);
    #1;
    check_outputs_zero("reset_rx_high");
    check_val("reset_no_we", we_cnt, we_before);
    check_val("reset_no_re", re_cnt, re_before);
    bus.rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compare_all("reset_mid_burst");
    cmd_status();
    compare_all("status_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_cmd_ctrl.md
SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

Interface
REQ-001 SHALL have parameters: DATA_SIZE, default 16, SPI word width; ADDR_WIDTH, default 6, register address width; CNT_WIDTH, default 8, burst count field width.
REQ-002 SHALL have one clock and reset is asynchronous and active-low: clk  input  1  system clock; rst_n  input  1  async active-low reset.
REQ-003 cs  input  1  SPI chip select, active-low, asynchronous to clk.
REQ-004 rx_valid  input  1  level from SPI slave; high while a complete received word is held.
REQ-005 rx_data  input  DATA_SIZE  received word, stable while rx_valid high.
REQ-006 tx_valid  output  1  load strobe to SPI slave transmit register.
REQ-007 tx_data  output  DATA_SIZE  word to transmit.
REQ-008 tx_ready  input  1  SPI slave transmit idle.
REQ-009 reg_we  output  1  register write strobe, one cycle per word.
REQ-010 reg_addr  output  ADDR_WIDTH  register address.
REQ-011 reg_wdata  output  DATA_SIZE  register write data.
REQ-012 reg_re  output  1  register read strobe; reg_rdata valid exactly one cycle later.
REQ-013 reg_rdata  input  DATA_SIZE  register read data.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 Word event SHALL be the rising edge of rx_valid (registered copy rx_valid_q), one-cycle pulse.
REQ-016 cs SHALL pass a 2-FF synchronizer; synchronized cs high SHALL force IDLE next cycle, clearing counters, no reg_we issued.
REQ-017 Header word fields: [15:14] opcode (00 NOP, 01 WRITE, 10 READ, 11 STATUS), [13:8] start address, [7:0] count; burst length = count+1 (1..256).
REQ-018 States: IDLE, WR_DATA, RD_FETCH, RD_LOAD, RD_WAIT, ST_LOAD.
REQ-019 IDLE: word event decodes header; NOP stays IDLE; WRITE -> WR_DATA; READ -> RD_FETCH; STATUS -> ST_LOAD.
REQ-020 WR_DATA: each word event asserts reg_we one cycle with reg_addr = current address, reg_wdata = rx_data; address increments; after count+1 writes -> IDLE.
REQ-021 RD_FETCH: reg_re one cycle at current address -> RD_LOAD.
REQ-022 RD_LOAD: waits for tx_ready high, then holds tx_valid high exactly 2 cycles with tx_data = captured reg_rdata -> RD_WAIT.
REQ-023 RD_WAIT: word event (dummy word from master) increments address and burst counter; if count+1 words done -> IDLE, else -> RD_FETCH; dummy data ignored.
REQ-024 ST_LOAD: loads status word {8'hA5, frame_cnt[7:0]} via same tx_valid rule as REQ-022 -> IDLE.
REQ-025 Address SHALL wrap modulo 2^ADDR_WIDTH (63 -> 0); frame_cnt SHALL wrap 255 -> 0.
REQ-026 frame_cnt SHALL increment on every completed non-NOP command; aborted commands not counted.
REQ-027 Word event in RD_FETCH or RD_LOAD SHALL be ignored (master too fast); no state change.
REQ-028 tx_data SHALL hold its last value when tx_valid low.

Reset
REQ-029 rst_n low SHALL set state IDLE, all outputs 0, counters/address 0, rx_valid_q 1 (no spurious event from idle-high rx_valid), cs synchronizer 1.
REQ-030 Reset mid-burst SHALL abort with no further reg_we/reg_re.

Structure
REQ-031 Package spi_ctrl_pkg SHALL hold opcode enum, state enum, header field positions, STATUS_MAGIC = 8'hA5.
REQ-032 One sub-module spi_word_sync SHALL contain the cs synchronizer and rx_valid edge detector.

Verification
REQ-033 Header 16'h4A01 then words 16'h1111, 16'h2222 -> reg_we at addr 10, 11 with those data; IDLE; frame_cnt 1.
REQ-034 Header 16'h7F01 (WRITE addr 63, 2 words) -> writes at addr 63 then 0.
REQ-035 Header 16'h8502, reg model returns addr*3 -> tx_data 15, 18, 21 each with 2-cycle tx_valid after tx_ready high.
REQ-036 STATUS 16'hC000 after 3 completed commands -> tx_data 16'hA503.
REQ-037 cs raised after 1 of 4 WRITE data words -> IDLE within 3 cycles, no further reg_we, frame_cnt unchanged.
REQ-038 Release rst_n with rx_valid held high -> no word event, state IDLE, all outputs 0.
